dmem_ctrl: RTL

//  Data-memory controller on the pipeline's MEM-stage data port (dmemaddr/dmemdatain/dmemop/dmemwe).

---
 rtl/dmem_ctrl_pkg.sv | 33 +++
 rtl/dmem_ctrl_lane.sv | 42 ++++
 rtl/dmem_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared memop codes, FSM encodings and lane helpers for the MEM-stage data-memory controller.
package dmem_ctrl_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  function automatic logic memop_legal(input logic [2:0] op);
    return (op == MEMOP_B) || (op == MEMOP_H) || (op == MEMOP_W) ||
           (op == MEMOP_BU) || (op == MEMOP_HU);
  endfunction

  function automatic logic memop_misaligned(input logic [2:0] op, input logic [1:0] a);
    return (((op == MEMOP_H) || (op == MEMOP_HU)) && a[0]) ||
           ((op == MEMOP_W) && (a != 2'b00));
  endfunction

  // Natural alignment of the low address bits for the access size.
  function automatic logic [1:0] memop_align(input logic [2:0] op, input logic [1:0] a);
    logic [1:0] r;
    r = a;
    if ((op == MEMOP_H) || (op == MEMOP_HU)) r[0] = 1'b0;
    else if (op == MEMOP_W)                  r = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/dmem_ctrl_lane.sv
// dmem_lane: combinational byte-lane steering -- byte enables, store replication,
// load extraction and sign/zero extension from (op, a[1:0]).
module dmem_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rext
);

  logic [31:0] sh;
  assign sh = rword >> {a, 3'b000};

  always_comb begin
    be   = 4'b1111;
    wrep = wdata;
    rext = sh;
    case (op[1:0])
      2'b00: begin
        be   = 4'b0001 << a;
        wrep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be   = a[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    case (op)
      MEMOP_B:  rext = {{24{sh[7]}}, sh[7:0]};
      MEMOP_H:  rext = {{16{sh[15]}}, sh[15:0]};
      MEMOP_BU: rext = {24'h0, sh[7:0]};
      MEMOP_HU: rext = {16'h0, sh[15:0]};
      default:  ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte/half/word load-store to word RAM with byte enables, ack wait and timeout.
// Optional DMEM_MISALIGN_TRAP_EN: trap misaligned H/W instead of forcing natural alignment.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        l_we;
  logic [2:0]  l_op;
  logic [1:0]  l_a;
  logic [1:0]  a_al;
  logic        trap;
  logic [3:0]  st_be;
  logic [31:0] st_wrep;
  logic [31:0] ld_rext;
  logic [31:0] st_unused_rext;
  logic [3:0]  ld_unused_be;
  logic [31:0] ld_unused_wrep;
  logic        unused_addr;

  assign unused_addr = ^addr;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = memop_misaligned(op, addr[1:0]);
  assign a_al = addr[1:0];
`else
  assign trap = 1'b0;
  assign a_al = memop_align(op, addr[1:0]);
`endif

  // Store path steers the incoming request; load path extracts with the latched op/offset.
  dmem_lane u_st (
    .op(op), .a(a_al), .wdata(wdata), .rword(32'h0),
    .be(st_be), .wrep(st_wrep), .rext(st_unused_rext)
  );

  dmem_lane u_ld (
    .op(l_op), .a(l_a), .wdata(32'h0), .rword(ram_rdata),
    .be(ld_unused_be), .wrep(ld_unused_wrep), .rext(ld_rext)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      l_we      <= 1'b0;
      l_op      <= '0;
      l_a       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          l_we <= we;
          l_op <= op;
          l_a  <= a_al;
          if (!memop_legal(op) || trap) begin
            state <= S_RESP;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            state     <= S_REQ;
            cnt       <= '0;
            busy      <= 1'b1;
            ram_req   <= 1'b1;
            ram_we    <= we;
            ram_be    <= st_be;
            ram_addr  <= addr[ADDR_W-1:2];
            ram_wdata <= st_wrep;
          end
        end
        S_REQ: begin
          // Ack is tested first so an ack in the last allowed cycle is not an error.
          if (ram_ack) begin
            if (!l_we) rdata <= ld_rext;
            state   <= S_RESP;
            done    <= 1'b1;
            busy    <= 1'b0;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
          end else if (cnt == TO_LAST) begin
            state   <= S_RESP;
            done    <= 1'b1;
            err     <= 1'b1;
            busy    <= 1'b0;
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
